// File: rtl/ethernet_access_arbiter_pkg.sv
// Shared types for the Ethernet MAC register-port arbiter: FSM states,
// the latched access record and a phase-counter width helper.
package ethernet_access_arbiter_pkg;

  typedef logic [15:0] HalfWord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IDX_STB,
    ST_IDX_WAIT,
    ST_DAT_STB,
    ST_DAT_WAIT,
    ST_DONE
  } EthArbState_t;

  typedef struct packed {
    logic      we;
    logic [7:0] idx;
    HalfWord_t wdata;
  } EthRegReq_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_rr_arbiter2.sv
// Two-port round-robin grant logic; purely combinational, the parent
// registers the winner together with the request fields.
module eth_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic       grant_valid,
  output logic       grant
);

  always_comb begin
    grant_valid = enable & (|req);
    // On a tie the port that was not served last wins; otherwise the sole requester.
    grant       = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/ethernet_access_arbiter.sv
// Sequences atomic index-write / data-phase accesses to the external MAC
// chip for two requesters, with registered strobes and recovery gaps.
module ethernet_access_arbiter
  import ethernet_access_arbiter_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned WAIT_CYCLES  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [7:0]  reg_idx0,
  input  logic [7:0]  reg_idx1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        cs_n,
  output logic        ior_n,
  output logic        iow_n,
  output logic        cmd,
  output logic [15:0] sd_out,
  output logic        sd_oe,
  input  logic [15:0] sd_in
);

  localparam int unsigned CW = $clog2(max2(PULSE_CYCLES, WAIT_CYCLES)) + 1;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(WAIT_CYCLES - 1);

  EthArbState_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  EthRegReq_t    xfer_q, xfer_d;

  logic [1:0]  ack_q, ack_d;
  HalfWord_t   rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        cs_n_q, cs_n_d;
  logic        ior_n_q, ior_n_d;
  logic        iow_n_q, iow_n_d;
  logic        cmd_q, cmd_d;
  HalfWord_t   sd_out_q, sd_out_d;
  logic        sd_oe_q, sd_oe_d;

  logic arb_valid;
  logic arb_grant;

  eth_rr_arbiter2 u_rr (
    .req         (req),
    .last_grant  (last_grant_q),
    .enable      (state_q == ST_IDLE),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    xfer_d       = xfer_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_IDX_STB;
          cnt_d   = PULSE_LOAD;
          grant_d = arb_grant;
          xfer_d  = arb_grant ? '{we: we[1], idx: reg_idx1, wdata: wdata1}
                              : '{we: we[0], idx: reg_idx0, wdata: wdata0};
        end
      end
      ST_IDX_STB: begin
        if (cnt_q == '0) begin
          state_d = ST_IDX_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_IDX_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DAT_STB;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DAT_STB: begin
        if (cnt_q == '0) begin
          if (!xfer_q.we) rdata_d = sd_in;
          state_d = ST_DAT_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DAT_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        cnt_d        = '0;
        last_grant_d = grant_q;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    cs_n_d   = 1'b1;
    ior_n_d  = 1'b1;
    iow_n_d  = 1'b1;
    sd_oe_d  = 1'b0;
    cmd_d    = cmd_q;
    sd_out_d = sd_out_q;
    ack_d    = '0;
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE: cmd_d = 1'b0;
      ST_IDX_STB: begin
        cs_n_d   = 1'b0;
        iow_n_d  = 1'b0;
        cmd_d    = 1'b0;
        sd_oe_d  = 1'b1;
        sd_out_d = {8'h00, xfer_d.idx};
      end
      ST_IDX_WAIT: sd_oe_d = (state_q == ST_IDX_STB);
      ST_DAT_STB: begin
        cs_n_d = 1'b0;
        cmd_d  = 1'b1;
        if (xfer_d.we) begin
          iow_n_d  = 1'b0;
          sd_oe_d  = 1'b1;
          sd_out_d = xfer_d.wdata;
        end else begin
          ior_n_d = 1'b0;
        end
      end
      ST_DAT_WAIT: sd_oe_d = (state_q == ST_DAT_STB) && xfer_d.we;
      ST_DONE: ack_d = grant_d ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      xfer_q       <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      ior_n_q      <= 1'b1;
      iow_n_q      <= 1'b1;
      cmd_q        <= 1'b0;
      sd_out_q     <= '0;
      sd_oe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      xfer_q       <= xfer_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      cs_n_q       <= cs_n_d;
      ior_n_q      <= ior_n_d;
      iow_n_q      <= iow_n_d;
      cmd_q        <= cmd_d;
      sd_out_q     <= sd_out_d;
      sd_oe_q      <= sd_oe_d;
    end
  end

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign cs_n   = cs_n_q;
  assign ior_n  = ior_n_q;
  assign iow_n  = iow_n_q;
  assign cmd    = cmd_q;
  assign sd_out = sd_out_q;
  assign sd_oe  = sd_oe_q;

endmodule

// File: tb/tb_ethernet_access_arbiter.sv
// Directed bench for ethernet_access_arbiter: per-cycle pin traces for a
// table of accesses, round-robin pairs, and reset during a data strobe.
module tb_ethernet_access_arbiter;

  localparam int P     = 2;
  localparam int W     = 6;
  localparam int ACK_K = 2*P + 2*W + 1;
  localparam int PERIOD = 2*P + 2*W + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we;
  logic [7:0]  reg_idx0, reg_idx1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        busy, cs_n, ior_n, iow_n, cmd, sd_oe;
  logic [15:0] sd_out, sd_in;
  logic [15:0] chip_val;

  int checks = 0;
  int errors = 0;

  ethernet_access_arbiter #(.PULSE_CYCLES(P), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .reg_idx0(reg_idx0), .reg_idx1(reg_idx1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .busy(busy), .cs_n(cs_n), .ior_n(ior_n), .iow_n(iow_n),
    .cmd(cmd), .sd_out(sd_out), .sd_oe(sd_oe), .sd_in(sd_in)
  );

  always #5 clk = ~clk;

  // Chip model: drives its register value only while the read strobe is low.
  always_comb sd_in = (!ior_n) ? chip_val : 16'hDEAD;

  typedef struct {
    int          port;
    logic        wr;
    logic [7:0]  idx;
    logic [15:0] wdata;
    logic [15:0] chip;
    logic        mutate;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    logic [6:0]  exp_pins;
    logic        e_cs, e_ior, e_iow, e_oe, e_busy;
    logic [1:0]  e_ack;
    chip_val = v.chip;
    we[v.port] = v.wr;
    if (v.port == 0) begin reg_idx0 = v.idx; wdata0 = v.wdata; end
    else             begin reg_idx1 = v.idx; wdata1 = v.wdata; end
    req[v.port] = 1'b1;
    for (int k = 1; k <= ACK_K + 1; k++) begin
      @(posedge clk) #1;
      e_cs = 1; e_ior = 1; e_iow = 1; e_oe = 0; e_ack = 2'b00;
      e_busy = (k <= ACK_K);
      if (k <= P) begin
        e_cs = 0; e_iow = 0; e_oe = 1;
        check($sformatf("v%0d k%0d idx cmd", vi, k), 32'(cmd), 32'(0));
        check($sformatf("v%0d k%0d idx sd_out", vi, k), 32'(sd_out), {24'h0, v.idx});
      end else if (k == P + 1) begin
        e_oe = 1;
      end else if (k > P + W && k <= 2*P + W) begin
        e_cs = 0;
        check($sformatf("v%0d k%0d dat cmd", vi, k), 32'(cmd), 32'(1));
        if (v.wr) begin
          e_iow = 0; e_oe = 1;
          check($sformatf("v%0d k%0d dat sd_out", vi, k), 32'(sd_out), {16'h0, v.wdata});
        end else begin
          e_ior = 0;
        end
      end else if (k == 2*P + W + 1) begin
        e_oe = v.wr;
      end else if (k == ACK_K) begin
        e_ack = (v.port == 1) ? 2'b10 : 2'b01;
        check($sformatf("v%0d rdata", vi), 32'(rdata), {16'h0, v.exp_rdata});
      end
      exp_pins = {e_cs, e_ior, e_iow, e_oe, e_ack, e_busy};
      check($sformatf("v%0d k%0d pins{cs,ior,iow,oe,ack,busy}", vi, k),
            32'({cs_n, ior_n, iow_n, sd_oe, ack, busy}), 32'(exp_pins));
      if (v.mutate && k == 1) begin
        if (v.port == 0) begin reg_idx0 = 8'h77; wdata0 = 16'h9999; end
        else             begin reg_idx1 = 8'h77; wdata1 = 16'h9999; end
      end
      if (k == ACK_K) req[v.port] = 1'b0;
    end
  endtask

  task automatic run_pair(input string name, input int first);
    int t [2];
    t[0] = 0; t[1] = 0;
    we = 2'b11;
    reg_idx0 = 8'h10; wdata0 = 16'h1111;
    reg_idx1 = 8'h20; wdata1 = 16'h2222;
    req = 2'b11;
    for (int k = 1; k <= 3 * PERIOD; k++) begin
      @(posedge clk) #1;
      for (int p = 0; p < 2; p++) begin
        if (ack[p] && t[p] == 0) begin
          t[p] = k;
          req[p] = 1'b0;
        end
      end
      if (t[0] != 0 && t[1] != 0) break;
    end
    req = 2'b00;
    check($sformatf("%s first port%0d ack cycle", name, first), 32'(t[first]), 32'(ACK_K));
    check($sformatf("%s second port%0d ack cycle", name, 1 - first), 32'(t[1 - first]),
          32'(ACK_K + PERIOD));
    @(posedge clk) #1;
  endtask

  initial begin
    int ack_seen;
    int busy_seen;
    vecs[0] = '{port: 0, wr: 1'b1, idx: 8'hFE, wdata: 16'h00FF, chip: 16'h0000, mutate: 1'b0, exp_rdata: 16'h0000};
    vecs[1] = '{port: 1, wr: 1'b0, idx: 8'h28, wdata: 16'h0000, chip: 16'h9000, mutate: 1'b0, exp_rdata: 16'h9000};
    vecs[2] = '{port: 0, wr: 1'b0, idx: 8'h5A, wdata: 16'h0000, chip: 16'hA5C3, mutate: 1'b0, exp_rdata: 16'hA5C3};
    vecs[3] = '{port: 1, wr: 1'b1, idx: 8'h01, wdata: 16'hBEEF, chip: 16'h0000, mutate: 1'b0, exp_rdata: 16'hA5C3};
    vecs[4] = '{port: 0, wr: 1'b1, idx: 8'h33, wdata: 16'h1234, chip: 16'h0000, mutate: 1'b1, exp_rdata: 16'hA5C3};

    rst_n = 1'b0; req = 2'b00; we = 2'b00;
    reg_idx0 = '0; reg_idx1 = '0; wdata0 = '0; wdata1 = '0; chip_val = '0;
    do_reset();
    check("reset strobes{cs,ior,iow}", 32'({cs_n, ior_n, iow_n}), 32'(3'b111));
    check("reset sd_oe", 32'(sd_oe), 32'(0));
    check("reset ack", 32'(ack), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset rdata", 32'(rdata), 32'(0));

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Port 0 was served last, so a tie now goes to port 1.
    run_pair("rr after port0", 1);
    do_reset();
    run_pair("tie from reset", 0);
    run_pair("tie repeat", 0);

    // Reset asserted in the middle of a write data strobe.
    we[0] = 1'b1; reg_idx0 = 8'h44; wdata0 = 16'h4444; req[0] = 1'b1;
    repeat (P + W + 1) @(posedge clk);
    #1;
    check("pre-reset data strobe cs_n", 32'(cs_n), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    check("async reset pins{cs,ior,iow,oe}", 32'({cs_n, ior_n, iow_n, sd_oe}), 32'(4'b1110));
    check("async reset busy", 32'(busy), 32'(0));
    req = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    ack_seen = 0; busy_seen = 0;
    for (int k = 0; k < ACK_K + 4; k++) begin
      @(posedge clk) #1;
      if (ack != 2'b00) ack_seen++;
      if (busy) busy_seen++;
    end
    check("post-reset ack count", 32'(ack_seen), 32'(0));
    check("post-reset busy count", 32'(busy_seen), 32'(0));
    check("post-reset cs_n", 32'(cs_n), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
